wb_fwd_ctrl: RTL and testbench

Write-side counterpart of the decode/register-file stage for the pipelined core. Takes each instruction's results from EX, carries them through the MEM/WB pipeline registers and selects the write-back value. Drives the register-file write port and returns forwarded operands and a load-use stall to decode. Also counts retired instructions.

---
 rtl/wb_fwd_ctrl.sv | 131 +++++++++++++
 tb/tb_wb_fwd_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fwd_ctrl.sv
// MEM/WB pipeline registers, write-back select, register-file write port,
// operand forwarding to decode, load-use stall and retired-instruction count.
module wb_fwd_ctrl #(
    parameter int XLEN   = 32,
    parameter int RCNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_rf_we,
    input  logic [4:0]        ex_wR,
    input  logic [1:0]        ex_wd_sel,
    input  logic [XLEN-1:0]   ex_alu_c,
    input  logic [XLEN-1:0]   ex_pc4,
    input  logic [XLEN-1:0]   ex_ext,
    input  logic [XLEN-1:0]   dram_rd,
    input  logic [4:0]        id_rR1,
    input  logic [4:0]        id_rR2,
    output logic              rf_we,
    output logic [4:0]        rf_wR,
    output logic [XLEN-1:0]   rf_wD,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [XLEN-1:0]   fwd1_data,
    output logic [XLEN-1:0]   fwd2_data,
    output logic              load_use_stall,
    output logic [RCNT_W-1:0] retired
);

    localparam logic [1:0] ALU_C    = 2'd0;
    localparam logic [1:0] DRAM_RD  = 2'd1;
    localparam logic [1:0] NPC_PC4  = 2'd2;
    localparam logic [1:0] SEXT_EXT = 2'd3;

    logic            mem_valid;
    logic            mem_we;
    logic [4:0]      mem_wR;
    logic [1:0]      mem_wd_sel;
    logic [XLEN-1:0] mem_alu_c;
    logic [XLEN-1:0] mem_pc4;
    logic [XLEN-1:0] mem_ext;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] ex_data;
    logic            wb_valid;
    logic            ex_writes;

    assign ex_writes = ex_valid & ex_rf_we;

    always_comb begin
        ex_data = ex_alu_c;
        case (ex_wd_sel)
            NPC_PC4:  ex_data = ex_pc4;
            SEXT_EXT: ex_data = ex_ext;
            default:  ex_data = ex_alu_c;
        endcase
    end

    always_comb begin
        mem_data = mem_alu_c;
        case (mem_wd_sel)
            ALU_C:    mem_data = mem_alu_c;
            DRAM_RD:  mem_data = dram_rd;
            NPC_PC4:  mem_data = mem_pc4;
            SEXT_EXT: mem_data = mem_ext;
            default:  mem_data = mem_alu_c;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_wR     <= '0;
            mem_wd_sel <= ALU_C;
            mem_alu_c  <= '0;
            mem_pc4    <= '0;
            mem_ext    <= '0;
            wb_valid   <= 1'b0;
            rf_we      <= 1'b0;
            rf_wR      <= '0;
            rf_wD      <= '0;
            retired    <= '0;
        end else begin
            mem_valid  <= ex_valid;
            mem_we     <= ex_writes & (ex_wR != 5'd0);
            mem_wR     <= ex_wR;
            mem_wd_sel <= ex_wd_sel;
            mem_alu_c  <= ex_alu_c;
            mem_pc4    <= ex_pc4;
            mem_ext    <= ex_ext;
            wb_valid   <= mem_valid;
            rf_we      <= mem_we;
            rf_wR      <= mem_wR;
            rf_wD      <= mem_data;
            if (wb_valid)
                retired <= retired + RCNT_W'(1);
        end
    end

    // A load still in EX has no data yet: its match suppresses older stages
    // rather than letting stale MEM/WB values through.
    function automatic void fwd_lookup(input  logic [4:0]      rr,
                                       output logic            hit,
                                       output logic [XLEN-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (rr != 5'd0) begin
            if (ex_writes && ex_wR == rr) begin
                if (ex_wd_sel != DRAM_RD) begin
                    hit  = 1'b1;
                    data = ex_data;
                end
            end else if (mem_we && mem_wR == rr) begin
                hit  = 1'b1;
                data = mem_data;
            end else if (rf_we && rf_wR == rr) begin
                hit  = 1'b1;
                data = rf_wD;
            end
        end
    endfunction

    always_comb begin
        fwd_lookup(id_rR1, fwd1_hit, fwd1_data);
        fwd_lookup(id_rR2, fwd2_hit, fwd2_data);
    end

    assign load_use_stall = ex_writes && (ex_wd_sel == DRAM_RD) && (ex_wR != 5'd0) &&
                            ((id_rR1 == ex_wR) || (id_rR2 == ex_wR));

endmodule

// File: tb/tb_wb_fwd_ctrl.sv
// Bench for wb_fwd_ctrl: directed scenarios plus a randomized run checked
// against an issued-instruction log model (4-bit retire counter for wrap).
module tb_wb_fwd_ctrl;
    localparam int XLEN = 32;
    localparam int RW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid, ex_rf_we;
    logic [4:0]      ex_wR;
    logic [1:0]      ex_wd_sel;
    logic [XLEN-1:0] ex_alu_c, ex_pc4, ex_ext, dram_rd;
    logic [4:0]      id_rR1, id_rR2;
    logic            rf_we;
    logic [4:0]      rf_wR;
    logic [XLEN-1:0] rf_wD;
    logic            fwd1_hit, fwd2_hit;
    logic [XLEN-1:0] fwd1_data, fwd2_data;
    logic            load_use_stall;
    logic [RW-1:0]   retired;

    wb_fwd_ctrl #(.XLEN(XLEN), .RCNT_W(RW)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rf_we(ex_rf_we),
        .ex_wR(ex_wR), .ex_wd_sel(ex_wd_sel), .ex_alu_c(ex_alu_c),
        .ex_pc4(ex_pc4), .ex_ext(ex_ext), .dram_rd(dram_rd),
        .id_rR1(id_rR1), .id_rR2(id_rR2), .rf_we(rf_we), .rf_wR(rf_wR),
        .rf_wD(rf_wD), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .load_use_stall(load_use_stall), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        valid;
        logic        we;
        logic [4:0]  wR;
        logic [1:0]  sel;
        logic [31:0] alu, pc4, ext, res;
    } rec_t;

    rec_t        hist[$];
    rec_t        cur_ex;
    logic [31:0] cur_dr;
    int unsigned ret_cnt;

    function automatic rec_t mk(input logic v, input logic we, input logic [4:0] wr,
                                input logic [1:0] sel, input logic [31:0] alu,
                                input logic [31:0] pc4, input logic [31:0] ext);
        rec_t r;
        r.valid = v; r.we = we; r.wR = wr; r.sel = sel;
        r.alu = alu; r.pc4 = pc4; r.ext = ext; r.res = 32'h0;
        return r;
    endfunction

    function automatic rec_t bubble();
        return mk(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    endfunction

    function automatic logic [31:0] pick(input rec_t r, input logic [31:0] dr);
        case (r.sel)
            2'd1:    return dr;
            2'd2:    return r.pc4;
            2'd3:    return r.ext;
            default: return r.alu;
        endcase
    endfunction

    function automatic rec_t mem_r();
        if (hist.size() >= 1) return hist[hist.size()-1];
        return bubble();
    endfunction

    function automatic rec_t wb_r();
        if (hist.size() >= 2) return hist[hist.size()-2];
        return bubble();
    endfunction

    function automatic bit writes(input rec_t r);
        return r.valid && r.we && (r.wR != 5'd0);
    endfunction

    task automatic exp_fwd(input logic [4:0] rr, output logic hit, output logic [31:0] d);
        rec_t m, w;
        m = mem_r();
        w = wb_r();
        hit = 1'b0;
        d   = 32'h0;
        if (rr == 5'd0) return;
        if (cur_ex.valid && cur_ex.we && cur_ex.wR == rr) begin
            if (cur_ex.sel != 2'd1) begin
                hit = 1'b1;
                d   = pick(cur_ex, 32'h0);
            end
        end else if (writes(m) && m.wR == rr) begin
            hit = 1'b1;
            d   = pick(m, cur_dr);
        end else if (writes(w) && w.wR == rr) begin
            hit = 1'b1;
            d   = w.res;
        end
    endtask

    task automatic set_in(input rec_t e, input logic [31:0] dr,
                          input logic [4:0] r1, input logic [4:0] r2);
        ex_valid  = e.valid;
        ex_rf_we  = e.we;
        ex_wR     = e.wR;
        ex_wd_sel = e.sel;
        ex_alu_c  = e.alu;
        ex_pc4    = e.pc4;
        ex_ext    = e.ext;
        dram_rd   = dr;
        id_rR1    = r1;
        id_rR2    = r2;
        cur_ex    = e;
        cur_dr    = dr;
    endtask

    task automatic tick();
        rec_t w;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            ret_cnt = 0;
        end else begin
            w = wb_r();
            if (w.valid) ret_cnt++;
            if (hist.size() > 0) hist[hist.size()-1].res = pick(hist[hist.size()-1], cur_dr);
            hist.push_back(cur_ex);
            if (hist.size() > 2) void'(hist.pop_front());
        end
        #1;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(bubble(), 32'h0, 5'd0, 5'd0);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(bubble(), 32'h0, 5'd0, 5'd0);
        tick();
        tick();
        n_chk++; if (rf_we !== 1'b0 || rf_wD !== 32'h0 || retired !== 4'h0) begin
            n_fail++; $display("FAIL reset_init: rf_we=%b rf_wD=%h retired=%h, want 0/0/0", rf_we, rf_wD, retired);
        end
        rst = 1'b0;
        set_in(mk(1, 1, 5'd3, 2'd0, 32'h33, 32'h0, 32'h0), 32'h0, 5'd0, 5'd0);
        tick();
        set_in(mk(1, 1, 5'd4, 2'd0, 32'h44, 32'h0, 32'h0), 32'h0, 5'd0, 5'd0);
        tick();
        set_in(bubble(), 32'h0, 5'd0, 5'd0);
        #2;
        n_chk++; if (rf_we !== 1'b1 || rf_wR !== 5'd3) begin
            n_fail++; $display("FAIL reset_pre_wb: rf_we=%b rf_wR=%0d, want 1/3", rf_we, rf_wR);
        end
        rst = 1'b1;
        hist.delete();
        ret_cnt = 0;
        #1;
        n_chk++; if (rf_we !== 1'b0 || rf_wD !== 32'h0 || retired !== 4'h0) begin
            n_fail++; $display("FAIL reset_async: rf_we=%b rf_wD=%h retired=%h, want 0/0/0", rf_we, rf_wD, retired);
        end
        set_in(mk(1, 1, 5'd6, 2'd0, 32'h66, 32'h0, 32'h0), 32'h0, 5'd6, 5'd3);
        #1;
        n_chk++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h66 || fwd2_hit !== 1'b0) begin
            n_fail++; $display("FAIL reset_fwd: fwd1=%b/%h fwd2_hit=%b, want 1/66 0", fwd1_hit, fwd1_data, fwd2_hit);
        end
        set_in(bubble(), 32'h0, 5'd0, 5'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(bubble(), 32'h0, 5'd0, 5'd0);
            #2;
            n_chk++; if (rf_we !== 1'b0) begin
                n_fail++; $display("FAIL reset_dropped: cycle %0d rf_we=%b, want 0", i, rf_we);
            end
            tick();
        end
    endtask

    task automatic test_latency_mux();
        logic [1:0]  sels[3] = '{2'd0, 2'd2, 2'd3};
        logic [31:0] want[3] = '{32'h1234, 32'h104, 32'hFFFFF800};
        for (int i = 0; i < 3; i++) begin
            set_in(mk(1, 1, 5'd5, sels[i], 32'h1234, 32'h104, 32'hFFFFF800), 32'h0, 5'd0, 5'd0);
            tick();
            set_in(bubble(), 32'h0, 5'd0, 5'd0);
            #2;
            n_chk++; if (rf_we !== 1'b0) begin
                n_fail++; $display("FAIL latency_early: sel %0d rf_we=%b at t+1, want 0", sels[i], rf_we);
            end
            tick();
            #2;
            n_chk++; if (rf_we !== 1'b1 || rf_wR !== 5'd5 || rf_wD !== want[i]) begin
                n_fail++; $display("FAIL latency_mux: sel %0d got %b/%0d/%h, want 1/5/%h", sels[i], rf_we, rf_wR, rf_wD, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_forward_priority();
        flush(2);
        set_in(mk(1, 1, 5'd7, 2'd0, 32'd1, 32'h0, 32'h0), 32'h0, 5'd0, 5'd0);
        tick();
        set_in(mk(1, 1, 5'd7, 2'd0, 32'd2, 32'h0, 32'h0), 32'h0, 5'd0, 5'd0);
        tick();
        set_in(mk(1, 1, 5'd7, 2'd0, 32'd3, 32'h0, 32'h0), 32'h0, 5'd7, 5'd7);
        #2;
        n_chk++; if (fwd1_hit !== 1'b1 || fwd2_hit !== 1'b1 || fwd1_data !== 32'd3 || fwd2_data !== 32'd3) begin
            n_fail++; $display("FAIL fwd_ex: got %b/%h %b/%h, want 1/3 1/3", fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
        end
        set_in(mk(0, 1, 5'd7, 2'd0, 32'd3, 32'h0, 32'h0), 32'h0, 5'd7, 5'd7);
        #2;
        n_chk++; if (fwd1_hit !== 1'b1 || fwd2_hit !== 1'b1 || fwd1_data !== 32'd2 || fwd2_data !== 32'd2) begin
            n_fail++; $display("FAIL fwd_mem: got %b/%h %b/%h, want 1/2 1/2", fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
        end
        tick();
        flush(2);
        set_in(mk(1, 1, 5'd7, 2'd0, 32'd1, 32'h0, 32'h0), 32'h0, 5'd0, 5'd0);
        tick();
        set_in(bubble(), 32'h0, 5'd0, 5'd0);
        tick();
        set_in(bubble(), 32'h0, 5'd7, 5'd7);
        #2;
        n_chk++; if (fwd1_hit !== 1'b1 || fwd2_hit !== 1'b1 || fwd1_data !== 32'd1 || fwd2_data !== 32'd1) begin
            n_fail++; $display("FAIL fwd_wb: got %b/%h %b/%h, want 1/1 1/1", fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
        end
        tick();
    endtask

    task automatic test_load_use();
        flush(2);
        set_in(mk(1, 1, 5'd9, 2'd1, 32'hDEAD, 32'h0, 32'h0), 32'h1111, 5'd0, 5'd9);
        #2;
        n_chk++; if (load_use_stall !== 1'b1 || fwd2_hit !== 1'b0) begin
            n_fail++; $display("FAIL load_use_ex: stall=%b fwd2_hit=%b, want 1/0", load_use_stall, fwd2_hit);
        end
        tick();
        set_in(bubble(), 32'hCAFEF00D, 5'd0, 5'd9);
        #2;
        n_chk++; if (fwd2_hit !== 1'b1 || fwd2_data !== 32'hCAFEF00D || load_use_stall !== 1'b0) begin
            n_fail++; $display("FAIL load_use_mem: fwd2=%b/%h stall=%b, want 1/cafef00d 0", fwd2_hit, fwd2_data, load_use_stall);
        end
        tick();
        set_in(bubble(), 32'h0, 5'd0, 5'd0);
        #2;
        n_chk++; if (rf_we !== 1'b1 || rf_wR !== 5'd9 || rf_wD !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL load_wb: got %b/%0d/%h, want 1/9/cafef00d", rf_we, rf_wR, rf_wD);
        end
        tick();
    endtask

    task automatic test_x0();
        int unsigned base;
        flush(3);
        base = ret_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) set_in(mk(1, 1, 5'd0, 2'd0, 32'h77 + i, 32'h0, 32'h0), 32'h0, 5'd0, 5'd0);
            else       set_in(bubble(), 32'h0, 5'd0, 5'd0);
            #2;
            n_chk++; if (rf_we !== 1'b0 || fwd1_hit !== 1'b0) begin
                n_fail++; $display("FAIL x0_write: cycle %0d rf_we=%b fwd1_hit=%b, want 0/0", i, rf_we, fwd1_hit);
            end
            tick();
        end
        n_chk++; if (retired !== RW'(base + 3)) begin
            n_fail++; $display("FAIL x0_retired: got %0d, want %0d", retired, RW'(base + 3));
        end
    endtask

    task automatic test_counter_wrap();
        rst = 1'b1;
        set_in(bubble(), 32'h0, 5'd0, 5'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            set_in(mk(1, 0, 5'(i + 1), 2'd0, 32'h0, 32'h0, 32'h0), 32'h0, 5'd0, 5'd0);
            tick();
        end
        flush(3);
        n_chk++; if (retired !== 4'hF) begin
            n_fail++; $display("FAIL cnt_full: got %h, want f", retired);
        end
        set_in(mk(1, 0, 5'd2, 2'd0, 32'h0, 32'h0, 32'h0), 32'h0, 5'd0, 5'd0);
        tick();
        flush(3);
        n_chk++; if (retired !== 4'h0) begin
            n_fail++; $display("FAIL cnt_wrap: got %h, want 0", retired);
        end
        flush(5);
        n_chk++; if (retired !== 4'h0) begin
            n_fail++; $display("FAIL cnt_bubbles: got %h, want 0", retired);
        end
    endtask

    task automatic test_random();
        rec_t        e, w;
        logic        h1, h2;
        logic [31:0] d1, d2;
        logic        stall;
        for (int i = 0; i < 400; i++) begin
            e = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            set_in(e, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            #2;
            w = wb_r();
            exp_fwd(id_rR1, h1, d1);
            exp_fwd(id_rR2, h2, d2);
            stall = e.valid && e.we && e.sel == 2'd1 && e.wR != 5'd0 &&
                    (id_rR1 == e.wR || id_rR2 == e.wR);
            n_chk++; if (rf_we !== writes(w) || rf_wR !== w.wR || rf_wD !== w.res) begin
                n_fail++; $display("FAIL rnd_rf: cyc %0d got %b/%0d/%h, want %b/%0d/%h", i, rf_we, rf_wR, rf_wD, writes(w), w.wR, w.res);
            end
            n_chk++; if (fwd1_hit !== h1 || fwd1_data !== d1) begin
                n_fail++; $display("FAIL rnd_fwd1: cyc %0d got %b/%h, want %b/%h", i, fwd1_hit, fwd1_data, h1, d1);
            end
            n_chk++; if (fwd2_hit !== h2 || fwd2_data !== d2) begin
                n_fail++; $display("FAIL rnd_fwd2: cyc %0d got %b/%h, want %b/%h", i, fwd2_hit, fwd2_data, h2, d2);
            end
            n_chk++; if (load_use_stall !== stall) begin
                n_fail++; $display("FAIL rnd_stall: cyc %0d got %b, want %b", i, load_use_stall, stall);
            end
            n_chk++; if (retired !== RW'(ret_cnt)) begin
                n_fail++; $display("FAIL rnd_retired: cyc %0d got %0d, want %0d", i, retired, RW'(ret_cnt));
            end
            tick();
        end
    endtask

    initial begin
        ret_cnt = 0;
        test_reset();
        test_latency_mux();
        test_forward_priority();
        test_load_use();
        test_x0();
        test_counter_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
